// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 constants, flag indices and FSM states
//   EXP_W/MAN_W/BIAS : binary16 field widths and exponent bias
//   QNAN/POS_INF     : canonical encodings
//   FLAG_*           : bit positions inside the 4-bit flags vector
//   state_t          : iterative-unit FSM states
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - combinational decode of one FP16 operand
//   x       : FP16 operand
//   sign    : sign bit
//   expo    : biased exponent field
//   mant    : {hidden 1, fraction}, zero for zero/subnormal (flushed)
//   is_zero : zero or subnormal (subnormals are flushed to signed zero)
//   is_inf  : infinity
//   is_nan  : any NaN
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0]      x,
  output logic             sign,
  output logic [EXP_W-1:0] expo,
  output logic [MAN_W:0]   mant,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign exp_zero  = ~|x[EXP_W+MAN_W-1:MAN_W];
  assign exp_ones  = &x[EXP_W+MAN_W-1:MAN_W];
  assign frac_zero = ~|x[MAN_W-1:0];

  assign sign    = x[15];
  assign expo    = x[EXP_W+MAN_W-1:MAN_W];
  assign mant    = exp_zero ? '0 : {1'b1, x[MAN_W-1:0]};
  assign is_zero = exp_zero;
  assign is_inf  = exp_ones & frac_zero;
  assign is_nan  = exp_ones & ~frac_zero;

endmodule

// File: rtl/fp16_seq_divider.sv
// rtl/fp16_seq_divider.sv - iterative FP16 divider, one quotient bit per cycle
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : operand handshake; a = dividend, b = divisor
//   out_valid/out_ready : result handshake; q = quotient
//   flags               : {invalid, div_by_zero, overflow, underflow}
//   FP16_DIV_ROUND_NEAREST_EN : defined -> round-to-nearest-even, else truncate
module fp16_seq_divider
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic [3:0]  flags
);

  logic             sa, sb, za, zb, ia, ib, na, nb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;

  fp16_classify u_cls_a (.x(a), .sign(sa), .expo(ea), .mant(ma), .is_zero(za), .is_inf(ia), .is_nan(na));
  fp16_classify u_cls_b (.x(b), .sign(sb), .expo(eb), .mant(mb), .is_zero(zb), .is_inf(ib), .is_nan(nb));

  state_t           state;
  logic [3:0]       cnt;
  logic [11:0]      rem;
  logic [12:0]      quo;
  logic [MAN_W:0]   mant_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic             sign_r;

  // Restoring-division step. The first step runs on the accept edge straight
  // from the decoded inputs, so 12 DIVIDE cycles complete all 13 quotient bits.
  // rem < 2*divisor always holds, so the difference fits in 11 bits.
  logic [11:0] div_rem;
  logic [10:0] div_mb;
  logic [10:0] diff;
  logic        qbit;
  logic [11:0] rem_next;

  always_comb begin
    div_rem  = (state == IDLE) ? {1'b0, ma} : rem;
    div_mb   = (state == IDLE) ? mb : mant_b;
    qbit     = (div_rem >= {1'b0, div_mb});
    diff     = 11'(div_rem - {1'b0, div_mb});
    rem_next = qbit ? {diff, 1'b0} : {div_rem[10:0], 1'b0};
  end

  // Special-operand result, resolved in the accept cycle.
  logic        special;
  logic        sign_ab;
  logic [15:0] spec_q;
  logic [3:0]  spec_flags;

  always_comb begin
    sign_ab    = sa ^ sb;
    special    = za | zb | ia | ib | na | nb;
    spec_q     = '0;
    spec_flags = '0;
    if (na | nb | (za & zb) | (ia & ib)) begin
      spec_q                   = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (zb) begin
      spec_q                    = {sign_ab, POS_INF[14:0]};
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (ia) begin
      spec_q = {sign_ab, POS_INF[14:0]};
    end else begin
      spec_q = {sign_ab, 15'd0};
    end
  end

  // Normalisation, rounding and range check of the finished quotient.
  logic signed [6:0] e_raw, e_norm, e_fin;
  logic [9:0]        frac_t;
  logic [10:0]       frac_sum;
  logic              round_up;
  logic [15:0]       res_q;
  logic [3:0]        res_flags;
`ifdef FP16_DIV_ROUND_NEAREST_EN
  logic              guard, sticky;
`endif

  always_comb begin
    e_raw  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + $signed(7'(BIAS));
    e_norm = quo[12] ? e_raw : e_raw - 7'sd1;
    frac_t = quo[12] ? quo[11:2] : quo[10:1];
`ifdef FP16_DIV_ROUND_NEAREST_EN
    guard    = quo[12] ? quo[1] : quo[0];
    sticky   = (quo[12] & quo[0]) | (|rem);
    round_up = guard & (sticky | frac_t[0]);
`else
    round_up = 1'b0;
`endif
    // On carry-out the low 10 bits are already zero; only the exponent bumps.
    frac_sum  = {1'b0, frac_t} + {10'd0, round_up};
    e_fin     = e_norm + $signed({6'd0, frac_sum[10]});
    res_q     = {sign_r, e_fin[4:0], frac_sum[9:0]};
    res_flags = '0;
    if (e_fin >= 7'sd31) begin
      res_q                    = {sign_r, POS_INF[14:0]};
      res_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (e_fin <= 7'sd0) begin
      res_q                     = {sign_r, 15'd0};
      res_flags[FLAG_UNDERFLOW] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      flags     <= '0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      mant_b    <= '0;
      exp_a     <= '0;
      exp_b     <= '0;
      sign_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            exp_a    <= ea;
            exp_b    <= eb;
            sign_r   <= sign_ab;
            if (special) begin
              q         <= spec_q;
              flags     <= spec_flags;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rem    <= rem_next;
              quo    <= {12'd0, qbit};
              mant_b <= mb;
              cnt    <= 4'd12;
              state  <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_next;
          quo <= {quo[11:0], qbit};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= NORM;
        end
        NORM: begin
          q         <= res_q;
          flags     <= res_flags;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_seq_divider.sv
// tb/tb_fp16_seq_divider.sv - self-checking bench for fp16_seq_divider
module tb_fp16_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] q;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  fp16_seq_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference: exact rational division mA*2^eA / (mB*2^eB) with integer math.
  function automatic logic [19:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    int     ea, eb, fa, fb, e, frac;
    logic   s, za, zb, ia, ib, na, nb, guard, inexact;
    longint ma, mb, num, sig;
    ea = int'(x[14:10]); fa = int'(x[9:0]);
    eb = int'(y[14:10]); fb = int'(y[9:0]);
    s  = x[15] ^ y[15];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 31) && (fa == 0); ib = (eb == 31) && (fb == 0);
    na = (ea == 31) && (fa != 0); nb = (eb == 31) && (fb != 0);
    if (na || nb || (za && zb) || (ia && ib)) return {4'b1000, 16'h7E00};
    if (zb) return {4'b0100, s, 15'h7C00};
    if (ia) return {4'b0000, s, 15'h7C00};
    if (za || ib) return {4'b0000, s, 15'h0000};
    ma = 1024 + fa;
    mb = 1024 + fb;
    e  = ea - eb + 15;
    if (ma >= mb) num = ma << 11;
    else begin
      num = ma << 12;
      e   = e - 1;
    end
    sig     = num / mb;
    inexact = ((num % mb) != 0);
    frac    = int'((sig >> 1) & 1023);
    guard   = sig[0];
`ifdef FP16_DIV_ROUND_NEAREST_EN
    if (guard && (inexact || frac[0])) frac = frac + 1;
    if (frac == 1024) begin
      frac = 0;
      e    = e + 1;
    end
`else
    if (guard && inexact) frac = frac + 0;
`endif
    if (e >= 31) return {4'b0010, s, 15'h7C00};
    if (e <= 0) return {4'b0001, s, 15'h0000};
    return {4'b0000, s, 5'(e), 10'(frac)};
  endfunction

  function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
    if (x[14:10] == 5'd0 || x[14:10] == 5'd31 || y[14:10] == 5'd0 || y[14:10] == 5'd31)
      return 1;
    return 14;
  endfunction

  // Applies one operation; lat counts rising edges with the accept edge as 1.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] rq, output logic [3:0] rf, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    rq = q; rf = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (q !== 16'h0000) begin n_err++; $display("FAIL reset_q: got %h want 0000", q); end
    n_vec++; if (flags !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %h want 0", flags); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_table(input string name, input logic [15:0] ta[], input logic [15:0] tb[],
                            input logic [15:0] tq[], input logic [3:0] tf[], input int tl[]);
    logic [15:0] rq;
    logic [3:0]  rf;
    int          lat;
    for (int i = 0; i < ta.size(); i++) begin
      do_op(ta[i], tb[i], rq, rf, lat);
      n_vec++; if (rq !== tq[i]) begin n_err++; $display("FAIL %s_q[%0d]: %h/%h got %h want %h", name, i, ta[i], tb[i], rq, tq[i]); end
      n_vec++; if (rf !== tf[i]) begin n_err++; $display("FAIL %s_flags[%0d]: %h/%h got %b want %b", name, i, ta[i], tb[i], rf, tf[i]); end
      n_vec++; if (lat !== tl[i]) begin n_err++; $display("FAIL %s_latency[%0d]: %h/%h got %0d want %0d", name, i, ta[i], tb[i], lat, tl[i]); end
    end
  endtask

  task automatic test_normal();
    logic [15:0] ta[] = '{16'h3C00, 16'h4600, 16'h4000, 16'h4500};
    logic [15:0] tb[] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4200};
`ifdef FP16_DIV_ROUND_NEAREST_EN
    logic [15:0] tq[] = '{16'h3C00, 16'h4200, 16'h3955, 16'h3EAB};
`else
    logic [15:0] tq[] = '{16'h3C00, 16'h4200, 16'h3955, 16'h3EAA};
`endif
    logic [3:0]  tf[] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    int          tl[] = '{14, 14, 14, 14};
    test_table("normal", ta, tb, tq, tf, tl);
  endtask

  task automatic test_specials();
    logic [15:0] ta[] = '{16'h3C00, 16'h0000, 16'hC000, 16'h7E01, 16'h7C00, 16'hFC00, 16'h0001, 16'h3C00};
    logic [15:0] tb[] = '{16'h0000, 16'h0000, 16'h7C00, 16'h3C00, 16'h7C00, 16'h4000, 16'h3C00, 16'h8001};
    logic [15:0] tq[] = '{16'h7C00, 16'h7E00, 16'h8000, 16'h7E00, 16'h7E00, 16'hFC00, 16'h0000, 16'hFC00};
    logic [3:0]  tf[] = '{4'b0100, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0100};
    int          tl[] = '{1, 1, 1, 1, 1, 1, 1, 1};
    test_table("special", ta, tb, tq, tf, tl);
  endtask

  task automatic test_range();
    logic [15:0] ta[] = '{16'h7BFF, 16'h0400};
    logic [15:0] tb[] = '{16'h0400, 16'h7BFF};
    logic [15:0] tq[] = '{16'h7C00, 16'h0000};
    logic [3:0]  tf[] = '{4'b0010, 4'b0001};
    int          tl[] = '{14, 14};
    test_table("range", ta, tb, tq, tf, tl);
  endtask

  task automatic test_backpressure();
    logic [19:0] exp_r;
    logic [15:0] hold;
    int          w;
    exp_r = ref_div(16'h4500, 16'h4200);
    a = 16'h4500; b = 16'h4200; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h3C00; b = 16'h3C00;
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    hold = q;
    n_vec++; if (hold !== exp_r[15:0]) begin n_err++; $display("FAIL bp_result: got %h want %h", hold, exp_r[15:0]); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++; if (q !== hold || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: q %h valid %b want %h 1", i, q, out_valid, hold); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: valid %b ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] rq;
    logic [3:0]  rf;
    logic [19:0] exp_r;
    int          lat;
    a = 16'h4600; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid: valid %b ready %b want 0 1", out_valid, in_ready); end
    in_valid = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid: got %b want 0", out_valid); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_r = ref_div(16'h4000, 16'h4200);
    do_op(16'h4000, 16'h4200, rq, rf, lat);
    n_vec++; if (rq !== exp_r[15:0] || rf !== exp_r[19:16]) begin n_err++; $display("FAIL rst_next_op: got %h/%b want %h/%b", rq, rf, exp_r[15:0], exp_r[19:16]); end
    n_vec++; if (lat !== 14) begin n_err++; $display("FAIL rst_next_latency: got %0d want 14", lat); end
  endtask

  task automatic test_random();
    logic [15:0] x, y, rq;
    logic [3:0]  rf;
    logic [19:0] exp_r;
    int          lat, el;
    for (int i = 0; i < 300; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 9) < 8) begin
        x[14:10] = 5'($urandom_range(1, 30));
        y[14:10] = 5'($urandom_range(1, 30));
      end
      exp_r = ref_div(x, y);
      el    = ref_lat(x, y);
      do_op(x, y, rq, rf, lat);
      n_vec++; if (rq !== exp_r[15:0]) begin n_err++; $display("FAIL rand_q: %h/%h got %h want %h", x, y, rq, exp_r[15:0]); end
      n_vec++; if (rf !== exp_r[19:16]) begin n_err++; $display("FAIL rand_flags: %h/%h got %b want %b", x, y, rf, exp_r[19:16]); end
      n_vec++; if (lat !== el) begin n_err++; $display("FAIL rand_latency: %h/%h got %0d want %0d", x, y, lat, el); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_range();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
